// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared definitions for the audio echo stage. Holds the
//                default sample width, the saturation limits for that width
//                and the processing FSM state encoding.
//  Contents    : DATA_W_DEF, SAT_MAX_DEF, SAT_MIN_DEF, audio_state_e
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    // Default signed sample width per channel.
    localparam int DATA_W_DEF = 32;

    // Saturation limits for the default width. Instances with a different
    // width derive the equivalent limits from their own DATA_W.
    localparam logic [DATA_W_DEF-1:0] SAT_MAX_DEF = {1'b0, {(DATA_W_DEF-1){1'b1}}};
    localparam logic [DATA_W_DEF-1:0] SAT_MIN_DEF = {1'b1, {(DATA_W_DEF-1){1'b0}}};

    // Per-sample processing sequence.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_MIX   = 2'd2,
        ST_WRITE = 2'd3
    } audio_state_e;

endpackage : audio_pkg
`default_nettype wire

// File: rtl/echo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : echo_ram
//  Description : Simple dual-port synchronous RAM used as the echo delay
//                line. One write port, one read port, registered read data
//                (1-cycle latency). Contents are never reset so the array
//                maps onto block RAM.
//  Ports       : clk_i      - clock
//                we_i       - write enable
//                waddr_i    - write address
//                wdata_i    - write data
//                re_i       - read enable
//                raddr_i    - read address
//                rdata_o    - read data, valid the cycle after re_i
//  Revision    : 1.0 - initial release
// ============================================================================
module echo_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : echo_ram
`default_nettype wire

// File: rtl/audio_echo_stage.sv
`default_nettype none
// ============================================================================
//  Module      : audio_echo_stage
//  Description : Stereo echo effect. Each accepted sample pair is mixed with
//                the pair written DEPTH samples earlier, attenuated by an
//                arithmetic right shift and saturated. The delay line is
//                always written (raw input or the mixed sum) so the echo
//                continues seamlessly when re-enabled.
//  Ports       : CLOCK_50      - clock, rising edge
//                reset_n       - asynchronous active-low reset
//                sample_strobe - new input pair valid (one-cycle pulse)
//                left_in       - left input sample, signed
//                right_in      - right input sample, signed
//                echo_en       - output the mixed sum instead of the input
//                feedback_en   - store the mixed sum instead of the input
//                left_out      - processed left sample, held
//                right_out     - processed right sample, held
//                out_valid     - one-cycle pulse on output update
//                busy          - FSM not idle
//                drop_cnt      - strobes ignored while busy, saturating
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_echo_stage
    import audio_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 4096,
    parameter int ATTEN_SH = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              sample_strobe,
    input  logic [DATA_W-1:0] left_in,
    input  logic [DATA_W-1:0] right_in,
    input  logic              echo_en,
    input  logic              feedback_en,
    output logic [DATA_W-1:0] left_out,
    output logic [DATA_W-1:0] right_out,
    output logic              out_valid,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    audio_state_e      state_q;
    logic [DATA_W-1:0] in_l_q, in_r_q;
    logic              echo_q, fb_q;
    logic [AW-1:0]     wr_ptr_q;
    logic              primed_q;
    logic [DATA_W-1:0] out_l_q, out_r_q;
    logic [DATA_W-1:0] store_l_q, store_r_q;
    logic              valid_q;
    logic [7:0]        drop_q;

    // ------------------------------------------------------------------
    // Delay line
    // ------------------------------------------------------------------
    logic                  ram_re;
    logic                  ram_we;
    logic [2*DATA_W-1:0]   ram_rdata;

    // The read is launched in the accepting IDLE cycle so the data is
    // waiting in the RAM output register by the time MIX uses it. The RAM
    // output register holds its value through READ and MIX because no
    // further read is issued until the FSM is back in IDLE.
    assign ram_re = sample_strobe && (state_q == ST_IDLE);
    assign ram_we = (state_q == ST_WRITE);

    echo_ram #(
        .WIDTH (2*DATA_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_echo_ram (
        .clk_i   (CLOCK_50),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i ({store_l_q, store_r_q}),
        .re_i    (ram_re),
        .raddr_i (wr_ptr_q),
        .rdata_o (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Mix arithmetic (identical per channel)
    // ------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] mix_sat(
        input logic [DATA_W-1:0] smp,
        input logic [DATA_W-1:0] dly
    );
        logic [DATA_W-1:0] shifted;
        logic [DATA_W:0]   wide;
        shifted = $signed(dly) >>> ATTEN_SH;
        wide    = {smp[DATA_W-1], smp} + {shifted[DATA_W-1], shifted};
        // The two top bits disagree only when the sum left the DATA_W range.
        if (wide[DATA_W] != wide[DATA_W-1]) begin
            mix_sat = wide[DATA_W] ? SAT_MIN : SAT_MAX;
        end else begin
            mix_sat = wide[DATA_W-1:0];
        end
    endfunction

    logic [DATA_W-1:0] dly_l, dly_r;
    logic [DATA_W-1:0] sum_l_d, sum_r_d;

    // Until the line has wrapped once its contents are stale (RAM is never
    // cleared), so silence stands in for the delayed sample.
    always_comb begin
        dly_l   = primed_q ? ram_rdata[2*DATA_W-1:DATA_W] : '0;
        dly_r   = primed_q ? ram_rdata[DATA_W-1:0]        : '0;
        sum_l_d = mix_sat(in_l_q, dly_l);
        sum_r_d = mix_sat(in_r_q, dly_r);
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            in_l_q    <= '0;
            in_r_q    <= '0;
            echo_q    <= 1'b0;
            fb_q      <= 1'b0;
            wr_ptr_q  <= '0;
            primed_q  <= 1'b0;
            out_l_q   <= '0;
            out_r_q   <= '0;
            store_l_q <= '0;
            store_r_q <= '0;
            valid_q   <= 1'b0;
            drop_q    <= '0;
        end else begin
            valid_q <= 1'b0;

            if (sample_strobe && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (sample_strobe) begin
                        in_l_q  <= left_in;
                        in_r_q  <= right_in;
                        echo_q  <= echo_en;
                        fb_q    <= feedback_en;
                        state_q <= ST_READ;
                    end
                end

                ST_READ: begin
                    state_q <= ST_MIX;
                end

                // Outputs and write data are registered on the MIX->WRITE
                // edge so they are visible, with out_valid, during WRITE:
                // three cycles after the accepting strobe.
                ST_MIX: begin
                    out_l_q   <= echo_q ? sum_l_d : in_l_q;
                    out_r_q   <= echo_q ? sum_r_d : in_r_q;
                    store_l_q <= fb_q ? sum_l_d : in_l_q;
                    store_r_q <= fb_q ? sum_r_d : in_r_q;
                    valid_q   <= 1'b1;
                    state_q   <= ST_WRITE;
                end

                ST_WRITE: begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (wr_ptr_q == AW'(DEPTH-1)) begin
                        primed_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign left_out  = out_l_q;
    assign right_out = out_r_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign drop_cnt  = drop_q;

endmodule : audio_echo_stage
`default_nettype wire
